// File: rtl/game_state_if.sv
//------------------------------------------------------------------------------
// game_state_if : frame/collision inputs and game status outputs for game_state
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface game_state_if;
    logic       frame_tick;
    logic       start;
    logic       death_collision;
    logic       win_collision;
    logic [3:0] current_level;
    logic [1:0] lives;
    logic       respawn;
    logic       freeze;
    logic [2:0] state;

    modport master (
        output frame_tick, start, death_collision, win_collision,
        input  current_level, lives, respawn, freeze, state
    );

    modport slave (
        input  frame_tick, start, death_collision, win_collision,
        output current_level, lives, respawn, freeze, state
    );
endinterface

`default_nettype wire

// File: rtl/game_state.sv
//------------------------------------------------------------------------------
// game_state : lives/level/phase controller for a frog-crossing game
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module game_state #(
    parameter int START_LIVES  = 3,
    parameter int MAX_LEVEL    = 9,
    parameter int DEATH_FRAMES = 30,
    parameter int WIN_FRAMES   = 30
) (
    input  logic         clk,
    input  logic         reset,
    game_state_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        DYING     = 3'd2,
        LEVEL_UP  = 3'd3,
        GAME_OVER = 3'd4,
        VICTORY   = 3'd5
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
    localparam logic [3:0] LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [5:0] DEATH_LAST = 6'(DEATH_FRAMES - 1);
    localparam logic [5:0] WIN_LAST   = 6'(WIN_FRAMES - 1);

    state_t     state_reg,   state_next;
    logic [3:0] level_reg,   level_next;
    logic [1:0] lives_reg,   lives_next;
    logic       respawn_reg, respawn_next;
    logic       freeze_reg,  freeze_next;
    logic       armed,       armed_next;
    logic [5:0] frame_cnt,   cnt_next;
    logic       new_game;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            level_reg   <= 4'd0;
            lives_reg   <= LIVES_INIT;
            respawn_reg <= 1'b0;
            freeze_reg  <= 1'b1;
            armed       <= 1'b0;
            frame_cnt   <= 6'd0;
        end else begin
            state_reg   <= state_next;
            level_reg   <= level_next;
            lives_reg   <= lives_next;
            respawn_reg <= respawn_next;
            freeze_reg  <= freeze_next;
            armed       <= armed_next;
            frame_cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        level_next   = level_reg;
        lives_next   = lives_reg;
        respawn_next = 1'b0;
        armed_next   = armed;
        cnt_next     = frame_cnt;
        new_game     = 1'b0;

        case (state_reg)
            IDLE, GAME_OVER, VICTORY: begin
                if (bus.start) new_game = 1'b1;
            end
            PLAY: begin
                // Win outranks death when both collide on the same cycle
                if (armed) begin
                    if (bus.win_collision) begin
                        state_next = LEVEL_UP;
                        cnt_next   = 6'd0;
                    end else if (bus.death_collision) begin
                        state_next = DYING;
                        cnt_next   = 6'd0;
                        if (lives_reg != 2'd0) lives_next = lives_reg - 2'd1;
                    end
                end
            end
            DYING: begin
                if (bus.frame_tick) begin
                    if (frame_cnt == DEATH_LAST) begin
                        if (lives_reg == 2'd0) begin
                            state_next = GAME_OVER;
                            level_next = 4'd0;
                        end else begin
                            state_next   = PLAY;
                            respawn_next = 1'b1;
                        end
                    end else begin
                        cnt_next = frame_cnt + 6'd1;
                    end
                end
            end
            LEVEL_UP: begin
                if (bus.frame_tick) begin
                    if (frame_cnt == WIN_LAST) begin
                        if (level_reg < LEVEL_MAX) begin
                            level_next   = level_reg + 4'd1;
                            state_next   = PLAY;
                            respawn_next = 1'b1;
                        end else begin
                            state_next = VICTORY;
                        end
                    end else begin
                        cnt_next = frame_cnt + 6'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                level_next = 4'd0;
            end
        endcase

        if (new_game) begin
            state_next   = PLAY;
            level_next   = 4'd1;
            lives_next   = LIVES_INIT;
            respawn_next = 1'b1;
        end

        // Collisions stay masked until a frame has passed at the new position
        if (respawn_next)
            armed_next = 1'b0;
        else if (bus.frame_tick && !respawn_reg)
            armed_next = 1'b1;

        freeze_next = (state_next != PLAY);
    end

    assign bus.state         = state_reg;
    assign bus.current_level = level_reg;
    assign bus.lives         = lives_reg;
    assign bus.respawn       = respawn_reg;
    assign bus.freeze        = freeze_reg;

endmodule

`default_nettype wire

// File: tb/tb_game_state.sv
//------------------------------------------------------------------------------
// tb_game_state : scoreboard bench for game_state (MAX_LEVEL=2 build)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_game_state;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] lvl;
        logic [1:0] lv;
        logic       rsp;
        logic       frz;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t e;

    game_state_if bus ();

    game_state #(
        .START_LIVES (3),
        .MAX_LEVEL   (2),
        .DEATH_FRAMES(30),
        .WIN_FRAMES  (30)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs();
        return {bus.state, bus.current_level, bus.lives, bus.respawn, bus.freeze};
    endfunction

    function automatic exp_t mk(input int st, input int lvl, input int lv, input int rsp, input int frz);
        return {3'(st), 4'(lvl), 2'(lv), 1'(rsp), 1'(frz)};
    endfunction

    // One clock with the given inputs; outputs are sampled 1ns after the edge
    task automatic cyc(input logic tick, input logic st, input logic d, input logic w);
        bus.frame_tick      = tick;
        bus.start           = st;
        bus.death_collision = d;
        bus.win_collision   = w;
        @(posedge clk);
        #1;
        bus.frame_tick      = 1'b0;
        bus.start           = 1'b0;
        bus.death_collision = 1'b0;
        bus.win_collision   = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        sb.push_back(mk(0, 0, 3, 0, 1));
        #1;
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL reset_values: got %h exp %h", obs(), e); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_start();
        sb.push_back(mk(1, 1, 3, 1, 0)); cyc(0, 1, 0, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL start_enter_play: got %h exp %h", obs(), e); end
        sb.push_back(mk(1, 1, 3, 0, 0)); cyc(0, 0, 0, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL start_respawn_width: got %h exp %h", obs(), e); end
    endtask

    task automatic test_death();
        sb.push_back(mk(1, 1, 3, 0, 0)); cyc(0, 0, 1, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL death_unarmed_ignored: got %h exp %h", obs(), e); end
        cyc(1, 0, 0, 0);
        sb.push_back(mk(2, 1, 2, 0, 1)); cyc(0, 0, 1, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL death_enter_dying: got %h exp %h", obs(), e); end
        sb.push_back(mk(2, 1, 2, 0, 1)); ticks(29);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL dying_29_ticks_hold: got %h exp %h", obs(), e); end
        sb.push_back(mk(1, 1, 2, 1, 0)); ticks(1);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL dying_exit_respawn: got %h exp %h", obs(), e); end
        sb.push_back(mk(1, 1, 2, 0, 0)); cyc(0, 0, 0, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL dying_respawn_width: got %h exp %h", obs(), e); end
        sb.push_back(mk(1, 1, 2, 0, 0)); cyc(0, 0, 1, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL stale_death_ignored: got %h exp %h", obs(), e); end
    endtask

    task automatic test_game_over();
        cyc(1, 0, 0, 0);
        sb.push_back(mk(2, 1, 1, 0, 1)); cyc(0, 0, 1, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL second_death: got %h exp %h", obs(), e); end
        ticks(30);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        sb.push_back(mk(2, 1, 0, 0, 1)); cyc(0, 0, 1, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL third_death: got %h exp %h", obs(), e); end
        sb.push_back(mk(4, 0, 0, 0, 1)); ticks(30);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL game_over: got %h exp %h", obs(), e); end
        sb.push_back(mk(4, 0, 0, 0, 1)); cyc(1, 0, 1, 1);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL game_over_hold: got %h exp %h", obs(), e); end
        sb.push_back(mk(1, 1, 3, 1, 0)); cyc(0, 1, 0, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL game_over_restart: got %h exp %h", obs(), e); end
    endtask

    task automatic test_win_priority();
        sb.push_back(mk(1, 1, 3, 0, 0)); cyc(0, 0, 0, 1);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL win_unarmed_ignored: got %h exp %h", obs(), e); end
        cyc(1, 0, 0, 0);
        sb.push_back(mk(3, 1, 3, 0, 1)); cyc(0, 0, 1, 1);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL win_over_death: got %h exp %h", obs(), e); end
        sb.push_back(mk(3, 1, 3, 0, 1)); cyc(0, 1, 0, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL start_in_level_up: got %h exp %h", obs(), e); end
        sb.push_back(mk(1, 2, 3, 1, 0)); ticks(30);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL level_up_to_2: got %h exp %h", obs(), e); end
    endtask

    task automatic test_victory();
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        sb.push_back(mk(3, 2, 3, 0, 1)); cyc(0, 0, 0, 1);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL win_at_max: got %h exp %h", obs(), e); end
        sb.push_back(mk(5, 2, 3, 0, 1)); ticks(30);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL victory: got %h exp %h", obs(), e); end
        sb.push_back(mk(5, 2, 3, 0, 1)); cyc(1, 0, 0, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL victory_hold: got %h exp %h", obs(), e); end
        sb.push_back(mk(1, 1, 3, 1, 0)); cyc(0, 1, 0, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL victory_restart: got %h exp %h", obs(), e); end
    endtask

    task automatic test_reset_mid_dying();
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        sb.push_back(mk(2, 1, 2, 0, 1)); cyc(0, 0, 1, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL pre_reset_dying: got %h exp %h", obs(), e); end
        ticks(15);
        reset = 1'b1;
        sb.push_back(mk(0, 0, 3, 0, 1));
        #2;
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL async_reset_mid_dying: got %h exp %h", obs(), e); end
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        sb.push_back(mk(0, 0, 3, 0, 1)); ticks(40);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL idle_after_reset: got %h exp %h", obs(), e); end
    endtask

    task automatic test_back_to_back();
        sb.push_back(mk(1, 1, 3, 1, 0)); cyc(1, 1, 0, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL start_with_tick: got %h exp %h", obs(), e); end
        sb.push_back(mk(1, 1, 3, 0, 0)); cyc(0, 1, 0, 0);
        e = sb.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL start_in_play_ignored: got %h exp %h", obs(), e); end
    endtask

    initial begin
        bus.frame_tick      = 1'b0;
        bus.start           = 1'b0;
        bus.death_collision = 1'b0;
        bus.win_collision   = 1'b0;
        test_reset();
        test_start();
        test_death();
        test_game_over();
        test_win_priority();
        test_victory();
        test_reset_mid_dying();
        test_back_to_back();
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
